// File: rtl/exe_hazard_ctrl_if.sv
// Interface between the execute-stage pipeline and the hazard/forwarding
// controller. The pipeline side (master) supplies register usage and stage
// status. The controller side (slave) returns forwarding selects and
// stall/flush controls.
interface exe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  // decode stage
  logic [REG_AW-1:0] d_rs0;
  logic [REG_AW-1:0] d_rs1;
  logic              d_rs0_used;
  logic              d_rs1_used;
  // execute stage
  logic [REG_AW-1:0] x_rs0;
  logic [REG_AW-1:0] x_rs1;
  logic              x_rs0_used;
  logic              x_rs1_used;
  logic              x_sp_used;
  logic [REG_AW-1:0] x_rd;
  logic              x_wen;
  logic              x_is_load;
  // memory stage
  logic [REG_AW-1:0] m_rd;
  logic              m_wen;
  logic              m_is_load;
  logic              m_sp_wen;
  // writeback stage
  logic [REG_AW-1:0] w_rd;
  logic              w_wen;
  // branch and data-memory handshake
  logic              br_taken;
  logic              mem_req;
  logic              mem_ready;
  // controls back to the pipeline
  logic              M_X_r0;
  logic              M_X_r1;
  logic              W_X_r0;
  logic              W_X_r1;
  logic              SP_forw;
  logic              stall_f;
  logic              stall_d;
  logic              bubble_x;
  logic              flush_d;
  logic              stall_xm;
  logic [1:0]        hz_state;

  modport master (
    output d_rs0, d_rs1, d_rs0_used, d_rs1_used,
    output x_rs0, x_rs1, x_rs0_used, x_rs1_used, x_sp_used, x_rd, x_wen, x_is_load,
    output m_rd, m_wen, m_is_load, m_sp_wen, w_rd, w_wen,
    output br_taken, mem_req, mem_ready,
    input  M_X_r0, M_X_r1, W_X_r0, W_X_r1, SP_forw,
    input  stall_f, stall_d, bubble_x, flush_d, stall_xm, hz_state
  );

  modport slave (
    input  d_rs0, d_rs1, d_rs0_used, d_rs1_used,
    input  x_rs0, x_rs1, x_rs0_used, x_rs1_used, x_sp_used, x_rd, x_wen, x_is_load,
    input  m_rd, m_wen, m_is_load, m_sp_wen, w_rd, w_wen,
    input  br_taken, mem_req, mem_ready,
    output M_X_r0, M_X_r1, W_X_r0, W_X_r1, SP_forw,
    output stall_f, stall_d, bubble_x, flush_d, stall_xm, hz_state
  );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard and forwarding controller.
// Forwarding selects are purely combinational. Stall, bubble and flush
// controls are Mealy outputs of a small RUN/LDUSE/MEMWAIT state machine,
// so they react in the same cycle the hazard is seen. hz_state is the
// registered state.
// Optional feature macro: HZ_PERF_CNT_EN adds saturating 32-bit counters
// stall_cyc, flush_cnt and memwait_cyc.
module exe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  exe_hazard_ctrl_if.slave hz
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cyc,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cyc
`endif
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_e;

  hz_state_e         state_reg, state_next;
  hz_state_e         saved_reg, saved_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  // Local copies of the execute sources, so both operand paths share one generate loop.
  logic [REG_AW-1:0] x_rs [2];
  logic [1:0]        x_used;
  logic [1:0]        m_x;
  logic [1:0]        w_x;

  assign x_rs[0]   = hz.x_rs0;
  assign x_rs[1]   = hz.x_rs1;
  assign x_used[0] = hz.x_rs0_used;
  assign x_used[1] = hz.x_rs1_used;

  // A load in memory has no data yet, so only non-load results forward from there.
  // Memory stage wins over writeback because it holds the younger value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign m_x[gi] = x_used[gi] & hz.m_wen & ~hz.m_is_load & (hz.m_rd == x_rs[gi]);
    assign w_x[gi] = x_used[gi] & hz.w_wen & (hz.w_rd == x_rs[gi]) & ~m_x[gi];
  end

  logic ldhz;
  logic memwait;

  assign ldhz = hz.x_wen & hz.x_is_load &
                ((hz.d_rs0_used & (hz.d_rs0 == hz.x_rd)) |
                 (hz.d_rs1_used & (hz.d_rs1 == hz.x_rd)));
  assign memwait = hz.mem_req & ~hz.mem_ready;

  logic stall_f_c, stall_d_c, stall_xm_c, bubble_c, flush_c;

  // Next-state and control decode; memory wait dominates everything, then branch, then load-use.
  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    cnt_next   = cnt_reg;
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    stall_xm_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (memwait) begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          stall_xm_c = 1'b1;
          saved_next = ST_RUN;
          state_next = ST_MEMWAIT;
        end else if (hz.br_taken) begin
          // The decode instruction is killed, so any load-use on it is moot.
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (ldhz) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          bubble_c  = 1'b1;
          cnt_next  = LD_INIT;
          if (LOAD_LAT > 1) state_next = ST_LDUSE;
        end
      end
      ST_LDUSE: begin
        if (memwait) begin
          // Counter is left untouched so the remaining load-use cycles resume afterwards.
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          stall_xm_c = 1'b1;
          saved_next = ST_LDUSE;
          state_next = ST_MEMWAIT;
        end else begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          bubble_c  = 1'b1;
          if (cnt_reg <= CW'(1)) begin
            cnt_next   = '0;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end
      ST_MEMWAIT: begin
        // The ready cycle already releases the pipeline.
        if (hz.mem_ready) begin
          state_next = saved_reg;
        end else begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          stall_xm_c = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, return-state and load counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      saved_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Every output is forced low while reset is held, including the combinational ones.
  assign hz.M_X_r0   = ~rst & m_x[0];
  assign hz.M_X_r1   = ~rst & m_x[1];
  assign hz.W_X_r0   = ~rst & w_x[0];
  assign hz.W_X_r1   = ~rst & w_x[1];
  assign hz.SP_forw  = ~rst & hz.x_sp_used & hz.m_sp_wen;
  assign hz.stall_f  = ~rst & stall_f_c;
  assign hz.stall_d  = ~rst & stall_d_c;
  assign hz.stall_xm = ~rst & stall_xm_c;
  assign hz.bubble_x = ~rst & bubble_c;
  assign hz.flush_d  = ~rst & flush_c;
  assign hz.hz_state = rst ? 2'd0 : state_reg;

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cyc_reg, flush_cnt_reg, memwait_cyc_reg;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_reg   <= '0;
      flush_cnt_reg   <= '0;
      memwait_cyc_reg <= '0;
    end else begin
      if (stall_d_c && stall_cyc_reg != 32'hFFFF_FFFF)
        stall_cyc_reg <= stall_cyc_reg + 32'd1;
      if (flush_c && flush_cnt_reg != 32'hFFFF_FFFF)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      if (state_reg == ST_MEMWAIT && memwait_cyc_reg != 32'hFFFF_FFFF)
        memwait_cyc_reg <= memwait_cyc_reg + 32'd1;
    end
  end

  assign stall_cyc   = stall_cyc_reg;
  assign flush_cnt   = flush_cnt_reg;
  assign memwait_cyc = memwait_cyc_reg;
`endif

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: a vector table for forwarding and
// branch flush in RUN, plus cycle-by-cycle sequences for load-use,
// memory wait and reset abort. LOAD_LAT is 3 here.
module tb_exe_hazard_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  exe_hazard_ctrl_if #(.REG_AW(5)) hz_if ();

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_cnt, memwait_cyc;
`endif

  exe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
`ifdef HZ_PERF_CNT_EN
    ,
    .stall_cyc   (stall_cyc),
    .flush_cnt   (flush_cnt),
    .memwait_cyc (memwait_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] x_rs0;
    logic       x_rs0_used;
    logic [4:0] x_rs1;
    logic       x_rs1_used;
    logic       x_sp_used;
    logic [4:0] m_rd;
    logic       m_wen;
    logic       m_is_load;
    logic       m_sp_wen;
    logic [4:0] w_rd;
    logic       w_wen;
    logic       br;
    logic [4:0] exp_fwd;  // {M_X_r0, M_X_r1, W_X_r0, W_X_r1, SP_forw}
    logic [1:0] exp_fb;   // {flush_d, bubble_x}
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz_if.d_rs0 = 5'd0;  hz_if.d_rs1 = 5'd0;
    hz_if.d_rs0_used = 1'b0; hz_if.d_rs1_used = 1'b0;
    hz_if.x_rs0 = 5'd0;  hz_if.x_rs1 = 5'd0;
    hz_if.x_rs0_used = 1'b0; hz_if.x_rs1_used = 1'b0; hz_if.x_sp_used = 1'b0;
    hz_if.x_rd = 5'd0;   hz_if.x_wen = 1'b0; hz_if.x_is_load = 1'b0;
    hz_if.m_rd = 5'd0;   hz_if.m_wen = 1'b0; hz_if.m_is_load = 1'b0; hz_if.m_sp_wen = 1'b0;
    hz_if.w_rd = 5'd0;   hz_if.w_wen = 1'b0;
    hz_if.br_taken = 1'b0; hz_if.mem_req = 1'b0; hz_if.mem_ready = 1'b0;
  endtask

  // One cycle of a sequence: drive at the negedge, sample 1 time unit later,
  // then move to the next negedge. exp = {hz_state, stall_f, stall_d, stall_xm, bubble_x, flush_d}.
  task automatic step(input string nm, input logic ld, input logic br,
                      input logic mreq, input logic mrdy, input logic r,
                      input logic [6:0] exp);
    logic [6:0] got;
    hz_if.x_rd = 5'd5; hz_if.x_wen = 1'b1; hz_if.x_is_load = ld;
    hz_if.d_rs1 = 5'd5; hz_if.d_rs1_used = 1'b1;
    hz_if.br_taken = br; hz_if.mem_req = mreq; hz_if.mem_ready = mrdy;
    rst = r;
    #1;
    got = {hz_if.hz_state, hz_if.stall_f, hz_if.stall_d, hz_if.stall_xm,
           hz_if.bubble_x, hz_if.flush_d};
    $display("step %s st/sf/sd/sxm/bub/fl=%b", nm, got);
    chk(nm, 32'(got), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] fwd;
    total = 0;
    bad   = 0;

    //            rs0 u0  rs1 u1 sp  mrd mw ml msp wrd ww br  fwd       fb
    vecs[0] = '{5'd3, 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 5'd3, 1, 0, 5'b10000, 2'b00};
    vecs[1] = '{5'd3, 1, 5'd0, 0, 0, 5'd3, 0, 0, 0, 5'd3, 1, 0, 5'b00100, 2'b00};
    vecs[2] = '{5'd3, 1, 5'd0, 0, 0, 5'd3, 1, 1, 0, 5'd3, 1, 0, 5'b00100, 2'b00};
    vecs[3] = '{5'd3, 1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 5'd3, 1, 0, 5'b01100, 2'b00};
    vecs[4] = '{5'd3, 1, 5'd7, 0, 0, 5'd7, 1, 0, 0, 5'd3, 1, 0, 5'b00100, 2'b00};
    vecs[5] = '{5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 1, 5'd0, 0, 0, 5'b00001, 2'b00};
    vecs[6] = '{5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 5'b00000, 2'b00};
    vecs[7] = '{5'd9, 1, 5'd9, 1, 0, 5'd4, 1, 0, 0, 5'd9, 1, 0, 5'b00110, 2'b00};
    vecs[8] = '{5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'b00000, 2'b11};

    // Reset with inputs that would otherwise forward and flush.
    clear_inputs();
    rst = 1'b1;
    hz_if.x_rs0 = 5'd3; hz_if.x_rs0_used = 1'b1;
    hz_if.m_rd = 5'd3; hz_if.m_wen = 1'b1; hz_if.br_taken = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("reset M_X_r0=%b flush_d=%b hz_state=%0d", hz_if.M_X_r0, hz_if.flush_d, hz_if.hz_state);
    chk("rst_mx0", 32'(hz_if.M_X_r0), 32'd0);
    chk("rst_flush", 32'(hz_if.flush_d), 32'd0);
    chk("rst_state", 32'(hz_if.hz_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);

    // Forwarding / branch vectors, all in RUN.
    for (int i = 0; i < 9; i++) begin
      hz_if.x_rs0 = vecs[i].x_rs0; hz_if.x_rs0_used = vecs[i].x_rs0_used;
      hz_if.x_rs1 = vecs[i].x_rs1; hz_if.x_rs1_used = vecs[i].x_rs1_used;
      hz_if.x_sp_used = vecs[i].x_sp_used;
      hz_if.m_rd = vecs[i].m_rd; hz_if.m_wen = vecs[i].m_wen;
      hz_if.m_is_load = vecs[i].m_is_load; hz_if.m_sp_wen = vecs[i].m_sp_wen;
      hz_if.w_rd = vecs[i].w_rd; hz_if.w_wen = vecs[i].w_wen;
      hz_if.br_taken = vecs[i].br;
      #1;
      fwd = {hz_if.M_X_r0, hz_if.M_X_r1, hz_if.W_X_r0, hz_if.W_X_r1, hz_if.SP_forw};
      $display("vec %0d fwd=%b flush=%b bubble=%b", i, fwd, hz_if.flush_d, hz_if.bubble_x);
      chk($sformatf("vec%0d_fwd", i), 32'(fwd), 32'(vecs[i].exp_fwd));
      chk($sformatf("vec%0d_fb", i), 32'({hz_if.flush_d, hz_if.bubble_x}), 32'(vecs[i].exp_fb));
      chk($sformatf("vec%0d_st", i), 32'(hz_if.hz_state), 32'd0);
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);

    // Load-use, LOAD_LAT=3: three stall cycles, state 0,1,1 then 0.
    //        name    ld br rq rd rst  st  sf sd sx bb fl
    step("ld_c1", 1, 0, 0, 0, 0, {2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("ld_c2", 0, 0, 0, 0, 0, {2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("ld_c3", 0, 0, 0, 0, 0, {2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("ld_c4", 0, 0, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Branch together with a load-use: flush wins, no stall.
    step("br_c1", 1, 1, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step("br_c2", 0, 0, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Memory wait entered from LDUSE with counter 1; resumes one LDUSE cycle.
    step("mw_c1", 1, 0, 0, 0, 0, {2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("mw_c2", 0, 0, 0, 0, 0, {2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("mw_c3", 0, 0, 1, 0, 0, {2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("mw_c4", 0, 0, 1, 0, 0, {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("mw_c5", 0, 0, 1, 0, 0, {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("mw_c6", 0, 0, 1, 0, 0, {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("mw_c7", 0, 0, 1, 1, 0, {2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step("mw_c8", 0, 0, 0, 0, 0, {2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step("mw_c9", 0, 0, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset in the second MEMWAIT cycle aborts to RUN.
    step("rs_c1", 0, 0, 1, 0, 0, {2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("rs_c2", 0, 0, 1, 0, 0, {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step("rs_c3", 0, 0, 1, 0, 1, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step("rs_c4", 0, 0, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef HZ_PERF_CNT_EN
    chk("perf_stall_rst", stall_cyc, 32'd0);
    chk("perf_flush_rst", flush_cnt, 32'd0);
    chk("perf_memwait_rst", memwait_cyc, 32'd0);
    step("pf_c1", 0, 1, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step("pf_c2", 0, 0, 0, 0, 0, {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    $display("perf stall=%0d flush=%0d memwait=%0d", stall_cyc, flush_cnt, memwait_cyc);
    chk("perf_flush_one", flush_cnt, 32'd1);
    chk("perf_stall_zero", stall_cyc, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
